serpar_stream_ctrl: RTL
=======================

# serpar_stream_ctrl

Sequencer on the host side of the masked cipher's byte-serial I/O buffer. Accepts one block of share bytes over a valid/ready stream and turns it into buffer write strobes. It then launches the cipher core and loads the core result into the buffer. Finally it drains the buffer MSB-byte-first over a valid/ready output stream. One instance per masked-cipher core; the buffer itself is a separate instance wired to the `buf_*` ports.

## Interface

Parameters:

- `NBYTES`, 112, bytes per block (buffer width / 8; 128*7 bits).
- `CNT_W`, 7, byte counter width; must satisfy 2^CNT_W ≥ NBYTES.

Ports:

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_data`  in  8  input share byte.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  block accepts input byte.
- `m_data`  out  8  output byte (= `buf_dout`).
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  sink accepts output byte.
- `m_last`  out  1  marks byte NBYTES-1 of output.
- `buf_din`  out  8  byte to buffer serial input (= `s_data`).
- `buf_dout`  in  8  buffer's top byte.
- `buf_wr`  out  1  buffer shift-in strobe.
- `buf_rd`  out  1  buffer shift-out strobe (zero fill).
- `buf_en`  out  1  buffer parallel-load strobe from core.
- `core_start`  out  1  one-cycle pulse launching the cipher.
- `core_done`  in  1  one-cycle pulse; core result valid on `data_core` in the same cycle.
- `busy`  out  1  high in every state except LOAD with `cnt`=0.

## Operation

- The state register holds LOAD, START, RUN or DRAIN. `cnt` is a CNT_W-bit byte counter.
- **LOAD**
  - `s_ready`=1.
  - `buf_wr` = `s_valid`.
  - On each accept: `cnt`++.
  - On accepting byte NBYTES-1: `cnt`←0, go to START.
- **START**
  - `core_start`=1 for exactly this cycle.
  - Next state is RUN.
- **RUN**
  - `s_ready`=0 and `m_valid`=0. No `buf_wr`/`buf_rd` is issued, so the buffer is stable for the core's parallel read.
  - `buf_en` = `core_done` (combinational), so the buffer loads at that edge.
  - On `core_done`, go to DRAIN.
- **DRAIN**
  - `m_valid`=1 and `m_data`=`buf_dout`.
  - `buf_rd` = `m_ready`.
  - On each handshake: `cnt`++.
  - `m_last` = (`cnt`==NBYTES-1).
  - On the last handshake: `cnt`←0, go to LOAD.
- Invariant: at most one of `buf_wr`, `buf_rd`, `buf_en` is high in any cycle.
- `core_done` outside RUN is ignored. `s_valid` outside LOAD is ignored (not accepted, no strobe).
- A stalled `m_ready`=0 holds `m_data`/`m_valid`/`cnt` unchanged indefinitely.
- Reset behaviour:
  - While `rst`=1, all outputs are 0 except pass-through `buf_din`/`m_data`. This includes `s_ready`, `buf_*` strobes, `core_start` and `busy`.
  - After reset: LOAD, `cnt`=0.
  - Reset mid-block in any state aborts that block. Buffer contents are not cleared; they are fully overwritten by the next NBYTES writes.
  - A core already running after an abort is the top level's responsibility. Its `core_done` is ignored because the controller is in LOAD.

## Timing

- Input throughput: 1 byte/cycle with `s_valid` held high; NBYTES cycles per block.
- Last input accepted at edge T. `core_start` is high in cycle T+1, and RUN begins at T+2.
- `core_done` in cycle D. The buffer loads at edge D, and `m_valid` is high from cycle D+1 with the first (most significant) result byte.
- Output throughput: 1 byte/cycle with `m_ready` held high. `s_ready` rises the cycle after the last output handshake.
- Minimum block period: 2·NBYTES + 2 + core latency cycles.
- Outputs are combinational from state/`cnt` and handshake inputs only. There is no combinational path `s_valid`→`s_ready` or `m_ready`→`m_valid`.

## Structure

- Shared header `serpar_defs.vh` holds:
  - the NBYTES/CNT_W defaults;
  - the 2-bit state encodings LOAD=0, START=1, RUN=2, DRAIN=3.
- Single module, no sub-module. The counter and FSM are inline.
- The top level wires this block to one byte-serial I/O buffer and one masked cipher core.

## Test plan

- **Reset:** hold `rst` 3 cycles with `s_valid`=1 → `s_ready`=0, all strobes 0. First cycle after reset, `s_ready`=1 and `cnt`=0.
- **Full block:**
  - Stimulus: feed bytes 0x00..0x6F back-to-back; model core with 5-cycle latency returning input XOR 0xA5 per byte.
  - Required: 112 `buf_wr`; `core_start` single pulse the cycle after byte 0x6F; output 0xA5..0xCA in order; `m_last` only on the 112th byte.
- **Backpressure:** random `s_valid` gaps and `m_ready` gaps (50%) → byte order and count unchanged; `m_data` stable while stalled.
- **Spurious inputs:** `core_done` pulsed during LOAD and DRAIN, and `s_valid` during RUN → no `buf_en`, no accept, no state change.
- **Mid-operation reset:** reset after 40 input bytes, and separately after 50 output bytes → LOAD with `cnt`=0; the next full block produces the correct result.
- **Strobe exclusivity:** assertion over all runs → one-hot-or-zero of {`buf_wr`, `buf_rd`, `buf_en`}; `core_start` never high for 2 consecutive cycles.

Source files
------------

// File: rtl/serpar_stream_ctrl_pkg.sv
// Shared definitions for the byte-serial I/O buffer sequencer:
// block size defaults and the controller state encoding.
package serpar_stream_ctrl_pkg;

  localparam int unsigned NbytesDefault = 112;
  localparam int unsigned CntWDefault   = 7;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/serpar_stream_ctrl.sv
// Host-side sequencer for the masked cipher's byte-serial buffer: load a block,
// launch the core, capture its result, then drain the buffer MSB-byte-first.
module serpar_stream_ctrl
  import serpar_stream_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES = NbytesDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic [7:0] buf_din,
  input  logic [7:0] buf_dout,
  output logic       buf_wr,
  output logic       buf_rd,
  output logic       buf_en,
  output logic       core_start,
  input  logic       core_done,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NBYTES - 1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;

  logic w_s_ready, w_m_valid, w_m_last;
  logic w_buf_wr, w_buf_rd, w_buf_en;
  logic w_core_start, w_busy;

  assign buf_din = s_data;
  assign m_data  = buf_dout;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_s_ready    = 1'b0;
    w_m_valid    = 1'b0;
    w_m_last     = 1'b0;
    w_buf_wr     = 1'b0;
    w_buf_rd     = 1'b0;
    w_buf_en     = 1'b0;
    w_core_start = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      StLoad: begin
        w_s_ready = 1'b1;
        w_buf_wr  = s_valid;
        w_busy    = (r_cnt != '0);
        if (s_valid) begin
          if (r_cnt == LastCnt) begin
            w_cnt_d   = '0;
            w_state_d = StStart;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      StStart: begin
        w_core_start = 1'b1;
        w_state_d    = StRun;
      end
      StRun: begin
        // Buffer is left untouched here so the core can read it in parallel.
        w_buf_en = core_done;
        if (core_done) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_m_valid = 1'b1;
        w_buf_rd  = m_ready;
        w_m_last  = (r_cnt == LastCnt);
        if (m_ready) begin
          if (r_cnt == LastCnt) begin
            w_cnt_d   = '0;
            w_state_d = StLoad;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the state register.
  assign s_ready    = w_s_ready & ~rst;
  assign m_valid    = w_m_valid & ~rst;
  assign m_last     = w_m_last & ~rst;
  assign buf_wr     = w_buf_wr & ~rst;
  assign buf_rd     = w_buf_rd & ~rst;
  assign buf_en     = w_buf_en & ~rst;
  assign core_start = w_core_start & ~rst;
  assign busy       = w_busy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StLoad;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

endmodule
